// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial LSB-first adder with WIDTH-bit word framing
module serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             a,
   input  logic             b,
   input  logic             in_valid,
   input  logic             first,
   output logic             sum,
   output logic             sum_valid,
   output logic [WIDTH-1:0] sum_word,
   output logic             carry_out,
   output logic             overflow,
   output logic             word_valid
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   logic             carry_q;
   logic [CW-1:0]    bit_cnt;
   logic [WIDTH-1:0] shreg;

   logic [CW-1:0]    eff_cnt;
   logic             c_in;
   logic             s_bit;
   logic             c_gen;
   logic             last_bit;
   logic [WIDTH-1:0] s_msb;
   logic [WIDTH-1:0] shreg_nxt;

   // A word boundary (explicit first or counter wrap) forces carry-in to zero.
   always_comb begin
      eff_cnt   = first ? '0 : bit_cnt;
      c_in      = (eff_cnt == '0) ? 1'b0 : carry_q;
      s_bit     = a ^ b ^ c_in;
      c_gen     = (a & b) | (a & c_in) | (b & c_in);
      last_bit  = (eff_cnt == LAST);
      s_msb     = '0;
      s_msb[WIDTH-1] = s_bit;
      shreg_nxt = (shreg >> 1) | s_msb;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         carry_q    <= 1'b0;
         bit_cnt    <= '0;
         shreg      <= '0;
         sum        <= 1'b0;
         sum_valid  <= 1'b0;
         sum_word   <= '0;
         carry_out  <= 1'b0;
         overflow   <= 1'b0;
         word_valid <= 1'b0;
      end else begin
         sum_valid  <= in_valid;
         word_valid <= 1'b0;
         if (in_valid) begin
            sum     <= s_bit;
            carry_q <= c_gen;
            shreg   <= shreg_nxt;
            if (last_bit) begin
               bit_cnt    <= '0;
               word_valid <= 1'b1;
               sum_word   <= shreg_nxt;
               carry_out  <= c_gen;
               overflow   <= c_in ^ c_gen;
            end else begin
               bit_cnt <= eff_cnt + CW'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - self-checking bench for serial_adder
module tb_serial_adder;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         a = 1'b0;
   logic         b = 1'b0;
   logic         in_valid = 1'b0;
   logic         first = 1'b0;
   logic         sum;
   logic         sum_valid;
   logic [W-1:0] sum_word;
   logic         carry_out;
   logic         overflow;
   logic         word_valid;

   int tests = 0;
   int fails = 0;

   serial_adder #(.WIDTH(W)) dut (
      .clk(clk), .reset(reset), .a(a), .b(b), .in_valid(in_valid), .first(first),
      .sum(sum), .sum_valid(sum_valid), .sum_word(sum_word), .carry_out(carry_out),
      .overflow(overflow), .word_valid(word_valid)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Word-level model: accumulate operand bits, then take the arithmetic sum.
   int           idx;
   logic [W:0]   wa, wb, tot;
   logic         e_sum, e_sv, e_wv, e_cout, e_ovf, e_carry;
   logic [W-1:0] e_word;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         idx = 0; wa = '0; wb = '0;
         e_sum = 0; e_sv = 0; e_wv = 0; e_cout = 0; e_ovf = 0; e_carry = 0; e_word = '0;
      end else begin
         e_wv = 0;
         e_sv = in_valid;
         if (in_valid) begin
            if (first) begin
               idx = 0; wa = '0; wb = '0;
            end
            wa[idx] = a;
            wb[idx] = b;
            tot = wa + wb;
            e_sum = tot[idx];
            e_carry = tot[idx+1];
            idx++;
            if (idx == W) begin
               e_word = tot[W-1:0];
               e_cout = tot[W];
               e_ovf  = (wa[W-1] == wb[W-1]) && (tot[W-1] != wa[W-1]);
               e_wv   = 1;
               idx = 0; wa = '0; wb = '0;
            end
         end
      end
   end

   always @(negedge clk) begin
      check("sum", sum, e_sum);
      check("sum_valid", sum_valid, e_sv);
      check("word_valid", word_valid, e_wv);
      check("sum_word", sum_word, e_word);
      check("carry_out", carry_out, e_cout);
      check("overflow", overflow, e_ovf);
      check("carry_q", dut.carry_q, e_carry);
   end

   task automatic send(input logic ia, input logic ib, input logic v, input logic f);
      @(negedge clk);
      a = ia; b = ib; in_valid = v; first = f;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) send(0, 0, 0, 0);
   endtask

   task automatic word(input logic [W-1:0] wa_i, input logic [W-1:0] wb_i);
      for (int i = 0; i < W; i++) send(wa_i[i], wb_i[i], 1, i == 0);
   endtask

   // Called right after the last bit of a word has been driven.
   task automatic check_word(input string name, input logic [W-1:0] w, input logic co, input logic ov);
      @(posedge clk); #1;
      check({name, ".wv"}, word_valid, 1);
      check({name, ".word"}, sum_word, w);
      check({name, ".cout"}, carry_out, co);
      check({name, ".ovf"}, overflow, ov);
   endtask

   logic [3:0] fr_a, fr_b, fr_s, fr_c;

   initial begin
      #2;
      check("reset.sum", sum, 0);
      check("reset.sum_valid", sum_valid, 0);
      check("reset.sum_word", sum_word, 0);
      check("reset.word_valid", word_valid, 0);
      @(negedge clk);
      reset = 0;

      // free-running: (0,0),(1,1),(1,0),(0,0)
      fr_a = 4'b0110; fr_b = 4'b0010; fr_s = 4'b1000; fr_c = 4'b0110;
      for (int i = 0; i < 4; i++) begin
         send(fr_a[i], fr_b[i], 1, 0);
         @(posedge clk); #1;
         check("free.sum", sum, fr_s[i]);
         check("free.carry", dut.carry_q, fr_c[i]);
         check("free.sum_valid", sum_valid, 1);
      end

      word(8'h5A, 8'h3C);
      check_word("add", 8'h96, 0, 1);

      word(8'hFF, 8'h01);
      check_word("wrap", 8'h00, 1, 0);
      word(8'h01, 8'h01);
      check_word("next", 8'h02, 0, 0);
      idle(2);

      // gaps between bit 3 and bit 4; first during a gap must be ignored
      for (int i = 0; i < W; i++) begin
         if (i == 4) begin
            send(0, 0, 0, 0);
            send(1, 1, 0, 1);
            send(0, 0, 0, 0);
         end
         send(8'h5A >> i & 1, 8'h3C >> i & 1, 1, i == 0);
      end
      check_word("gap", 8'h96, 0, 1);
      idle(1);

      // abort at bit 5
      for (int i = 0; i < 5; i++) send(1, 1, 1, i == 0);
      word(8'h10, 8'h20);
      check_word("abort", 8'h30, 0, 0);
      idle(1);

      // async reset mid-word
      for (int i = 0; i < 3; i++) send(1, 1, 1, i == 0);
      @(posedge clk); #2;
      reset = 1; #1;
      check("areset.sum", sum, 0);
      check("areset.sum_valid", sum_valid, 0);
      check("areset.sum_word", sum_word, 0);
      check("areset.carry_out", carry_out, 0);
      check("areset.overflow", overflow, 0);
      check("areset.word_valid", word_valid, 0);
      @(negedge clk);
      reset = 0;
      word(8'h03, 8'h01);
      check_word("post", 8'h04, 0, 0);
      idle(3);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial, LSB-first two-operand adder with one carry flip-flop.
- Adds one bit of `a` and one bit of `b` per accepted clock cycle and emits one registered sum bit.
- Also frames the stream into WIDTH-bit words and reports the assembled parallel sum, the carry-out and the signed overflow per word.
- Sits between serial data sources and word-oriented consumers; usable as a plain free-running serial adder when framing outputs are ignored.

Parameters:
- WIDTH, 8, bits per word (legal range 1..64).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- a  input  1  operand A bit, LSB first.
- b  input  1  operand B bit, LSB first.
- in_valid  input  1  a/b valid this cycle. Tie high for free-running use.
- first  input  1  qualified by in_valid; marks bit 0 of a new word.
- sum  output  1  registered sum bit.
- sum_valid  output  1  sum holds a fresh bit; in_valid delayed one cycle.
- sum_word  output  WIDTH  last completed word sum.
- carry_out  output  1  final carry of the last completed word.
- overflow  output  1  signed overflow of the last completed word.
- word_valid  output  1  one-cycle pulse; sum_word/carry_out/overflow just updated.

Behaviour:
- Reset (async assert, released synchronously by system):
  - carry_q=0, bit_cnt=0, shift register=0.
  - sum=0, sum_valid=0, sum_word=0, carry_out=0, overflow=0, word_valid=0.
- Effective carry-in: c_in = (first | bit_cnt==0) ? 0 : carry_q.
- On a rising edge with in_valid=1:
  - sum <= a^b^c_in.
  - carry_q <= (a&b)|(a&c_in)|(b&c_in).
  - Shift register shifts right with a^b^c_in entering at the MSB.
  - bit_cnt <= (first ? 0 : bit_cnt) + 1.
  - Latency: one cycle from input bit to sum.
- On a rising edge with in_valid=0:
  - sum, carry_q, bit_cnt and the shift register hold.
  - sum_valid <= 0.
- sum_valid <= in_valid every cycle (not reset-gated beyond reset).
- Word completion, when the accepted bit is index WIDTH-1 (effective bit_cnt before increment == WIDTH-1):
  - Next cycle: word_valid=1.
  - sum_word = completed shift contents including this bit.
  - carry_out = carry generated by this bit.
  - overflow = c_in of this bit XOR carry generated by this bit.
  - bit_cnt wraps to 0; carry is therefore ignored at the next word start.
- word_valid is 1 for exactly one cycle per completed word, otherwise 0.
- sum_word, carry_out and overflow hold between completions.
- first asserted mid-word aborts the partial word:
  - No word_valid for it.
  - The new word starts at bit 0 with carry-in 0.
- first on a cycle with in_valid=0 is ignored.
- WIDTH=1: every accepted bit completes a word; carry-in always 0.
- Reset asserted mid-word discards the partial word and all outputs return to reset values asynchronously.
- Free-running mode (in_valid=1, first=0): after reset the carry chains across bits within each WIDTH-bit word. It behaves as the classic two-state (carry0/carry1) serial adder FSM.

Test Plan:
- Reset then free-run, WIDTH=8, bits (a,b) = (0,0), (1,1), (1,0), (0,0) -> sum one cycle later = 0, 0, 0, 1; carry_q after each bit = 0, 1, 1, 0; sum_valid=1 from cycle 2.
- Word add, WIDTH=8, first on bit 0, A=0x5A, B=0x3C LSB-first -> word_valid pulse one cycle after bit 7; sum_word=0x96, carry_out=0, overflow=1.
- Carry-out wrap, WIDTH=8, A=0xFF, B=0x01 -> sum_word=0x00, carry_out=1, overflow=0. Next word A=0x01, B=0x01 -> sum_word=0x02, confirming carry not propagated across the word.
- Gaps: 0x5A+0x3C with in_valid low for 3 cycles between bits 3 and 4 -> same result 0x96; sum/carry hold during gaps; sum_valid low during gaps.
- Abort: first re-asserted at bit 5 of a word, followed by a full word 0x10+0x20 -> single word_valid, sum_word=0x30.
- Async reset asserted mid-word between clock edges -> all outputs 0 immediately. After release, a fresh word 0x03+0x01 -> sum_word=0x04.
